// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard and pipeline-sequencing controller for the five-stage pipeline
//
// Purpose:
//   Drives the stall/flush/global_flush controls of the fetch2dec, dec2exec,
//   exec2mem and mem2wb pipeline registers and the PC update select.
//   Handles exceptions, data-memory waits, MDU occupancy, taken branches,
//   load-use hazards and instruction-memory waits, from highest to lowest
//   priority. Also holds the EPC register and a one-cycle exception ack.
//
// Configuration macro:
//   PIPELINE_CTRL_MDU_EN - when defined, the MDU down-counter and MDU_BUSY
//   state are built. When undefined, mdu_start is ignored and mdu_busy is 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   dec_rs/dec_rt, dec_uses_rs/rt   decode-stage source registers and use flags
//   exec_mem_read, exec_rd          exec-stage load and its destination
//   branch_taken                    exec-stage taken branch/jump
//   imem_wait, dmem_wait            memory not-ready indications
//   mdu_start                       MDU operation issuing from exec
//   exc_in, exc_pc                  mem-stage exception and faulting PC
//   pc_stall, pc_sel                PC hold and select (0 seq, 1 branch, 2 vector)
//   stall_*, flush_*, global_flush  pipeline register controls
//   mdu_busy                        MDU operation in progress
//   exc_ack, epc                    exception accepted pulse, captured PC

module pipeline_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MDU_LATENCY    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rt,
  input  logic                      dec_uses_rs,
  input  logic                      dec_uses_rt,
  input  logic                      exec_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] exec_rd,
  input  logic                      branch_taken,
  input  logic                      imem_wait,
  input  logic                      dmem_wait,
  input  logic                      mdu_start,
  input  logic                      exc_in,
  input  logic [ADDR_WIDTH-1:0]     exc_pc,
  output logic                      pc_stall,
  output logic [1:0]                pc_sel,
  output logic                      stall_fetch2dec,
  output logic                      stall_dec2exec,
  output logic                      stall_exec2mem,
  output logic                      stall_mem2wb,
  output logic                      flush_fetch2dec,
  output logic                      flush_dec2exec,
  output logic                      flush_exec2mem,
  output logic                      flush_mem2wb,
  output logic                      global_flush,
  output logic                      mdu_busy,
  output logic                      exc_ack,
  output logic [ADDR_WIDTH-1:0]     epc
);

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_VECTOR = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_MDU_BUSY    = 2'd1,
    ST_EXC_RECOVER = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
  logic                    exc_ack_q, exc_ack_d;

  logic                    load_use;
  logic                    exc_take;
  logic                    in_mdu;

  assign load_use = exec_mem_read && (exec_rd != '0) &&
                    ((dec_uses_rs && (dec_rs == exec_rd)) ||
                     (dec_uses_rt && (dec_rt == exec_rd)));

  // A second exception arriving during the recovery cycle is dropped.
  assign exc_take = exc_in && (state_q != ST_EXC_RECOVER);

`ifdef PIPELINE_CTRL_MDU_EN
  localparam int CNT_W = $clog2(MDU_LATENCY + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdu_issue;

  // The exec-stage instruction only leaves exec when data memory is ready,
  // so an MDU issue is accepted only then.
  assign mdu_issue = (state_q == ST_RUN) && mdu_start && !dmem_wait && !exc_take;
  assign in_mdu    = (state_q == ST_MDU_BUSY);

  always_comb begin
    cnt_d = cnt_q;
    if (exc_take) begin
      cnt_d = '0;
    end else if (mdu_issue) begin
      cnt_d = CNT_W'(MDU_LATENCY);
    end else if (in_mdu && (cnt_q != '0)) begin
      // Keeps counting through dmem_wait so MDU timing is independent of memory.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_mdu;

  assign in_mdu     = 1'b0;
  assign unused_mdu = mdu_start ^ (MDU_LATENCY > 0);
`endif

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    exc_ack_d = 1'b0;
    if (exc_take) begin
      state_d   = ST_EXC_RECOVER;
      epc_d     = exc_pc;
      exc_ack_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
`ifdef PIPELINE_CTRL_MDU_EN
          if (mdu_issue) begin
            state_d = ST_MDU_BUSY;
          end
`endif
        end
`ifdef PIPELINE_CTRL_MDU_EN
        ST_MDU_BUSY: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
`endif
        ST_EXC_RECOVER: state_d = ST_RUN;
        default:        state_d = ST_RUN;
      endcase
    end
  end

  // Hazard outputs, zero latency, highest priority first.
  always_comb begin
    pc_stall        = 1'b0;
    pc_sel          = PC_SEQ;
    stall_fetch2dec = 1'b0;
    stall_dec2exec  = 1'b0;
    stall_exec2mem  = 1'b0;
    stall_mem2wb    = 1'b0;
    flush_fetch2dec = 1'b0;
    flush_dec2exec  = 1'b0;
    flush_exec2mem  = 1'b0;
    flush_mem2wb    = 1'b0;
    global_flush    = 1'b0;
    if (exc_take) begin
      global_flush = 1'b1;
      pc_sel       = PC_VECTOR;
    end else if (dmem_wait) begin
      // mem2wb takes a bubble while the load in mem waits.
      pc_stall        = 1'b1;
      stall_fetch2dec = 1'b1;
      stall_dec2exec  = 1'b1;
      stall_exec2mem  = 1'b1;
      flush_mem2wb    = 1'b1;
    end else if (in_mdu) begin
      pc_stall        = 1'b1;
      stall_fetch2dec = 1'b1;
      stall_dec2exec  = 1'b1;
      flush_exec2mem  = 1'b1;
    end else if (branch_taken) begin
      pc_sel          = PC_BRANCH;
      flush_fetch2dec = 1'b1;
      flush_dec2exec  = 1'b1;
    end else if (load_use) begin
      pc_stall        = 1'b1;
      stall_fetch2dec = 1'b1;
      flush_dec2exec  = 1'b1;
    end else if (imem_wait) begin
      pc_stall        = 1'b1;
      flush_fetch2dec = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      epc_q     <= '0;
      exc_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      exc_ack_q <= exc_ack_d;
    end
  end

  assign mdu_busy = in_mdu;
  assign exc_ack  = exc_ack_q;
  assign epc      = epc_q;

endmodule
